// File: rtl/status_frame_tx.sv
// status_frame_tx: periodic or forced ASCII status frame ("$0=HH,1=HH...\r\n") sent over an 8N1 serial line.
// Ports: clk/rst (async, active-high); en gates new frames; force_send requests a frame now;
// ch_data holds NUM_CH channels of CH_W bits; tx is the serial line; busy and frame_done report progress.
module status_frame_tx #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 8,
  parameter int BAUD_DIV    = 434,
  parameter int PERIOD      = 5000000,
  parameter int CHANGE_ONLY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     force_send,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);
  localparam int D   = CH_W / 4;
  localparam int LEN = 3 + NUM_CH * (D + 3) - 1;
  localparam int KW  = $clog2(LEN + 1);
  localparam int BW  = $clog2(BAUD_DIV);
  localparam int PW  = $clog2(PERIOD);
  localparam int CW  = $clog2(NUM_CH + 1);
  localparam int SW  = $clog2(D + 3);
  typedef enum logic [1:0] {IDLE, SNAP, SEND, DONE} state_t;
  state_t state, next;
  logic [PW-1:0] per_cnt;
  logic [BW-1:0] baud_cnt;
  logic [3:0] bit_cnt;
  logic [KW-1:0] byte_cnt;
  logic [CW-1:0] ch;
  logic [SW-1:0] pos;
  logic [NUM_CH*CH_W-1:0] snap, last;
  logic [CH_W-1:0] ch_val;
  logic [3:0] nib;
  logic [7:0] body, cur;
  logic [2:0] bi;
  logic tick, pend, pend_forced, forced, accept, suppress;
  logic baud_end, byte_end, frame_end, pos_last;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction
  assign tick   = en && per_cnt == PW'(PERIOD - 1);
  assign accept = state == IDLE && pend && en;
  // The snapshot is loaded from ch_data at the end of SNAP, so ch_data is what it is about to hold.
  assign suppress  = CHANGE_ONLY != 0 && !forced && ch_data == last;
  assign baud_end  = baud_cnt == BW'(BAUD_DIV - 1);
  assign byte_end  = baud_end && bit_cnt == 4'd9;
  assign frame_end = byte_end && byte_cnt == KW'(LEN - 1);
  // The last channel has no trailing comma, so its field is one byte shorter.
  assign pos_last  = pos == SW'(D + 2) || (ch == CW'(NUM_CH - 1) && pos == SW'(D + 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) per_cnt <= '0;
    else per_cnt <= (!en || tick) ? '0 : per_cnt + PW'(1);
  // A trigger landing in the acceptance cycle itself re-arms pending rather than being lost.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend        <= 1'b0;
      pend_forced <= 1'b0;
      forced      <= 1'b0;
    end else begin
      pend        <= (pend && !accept) || tick || force_send;
      pend_forced <= (pend_forced && !accept) || force_send;
      if (accept) forced <= pend_forced;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? SNAP : IDLE;
      SNAP:    next = suppress ? IDLE : SEND;
      SEND:    next = frame_end ? DONE : SEND;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      snap     <= '0;
      last     <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      ch       <= '0;
      pos      <= '0;
    end else if (state == SNAP) begin
      snap     <= ch_data;
      if (!suppress) last <= ch_data;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      ch       <= '0;
      pos      <= '0;
    end else if (state == SEND) begin
      baud_cnt <= baud_end ? '0 : baud_cnt + BW'(1);
      if (baud_end) bit_cnt <= byte_end ? 4'd0 : bit_cnt + 4'd1;
      if (byte_end) begin
        byte_cnt <= byte_cnt + KW'(1);
        if (byte_cnt != '0) begin
          pos <= pos_last ? '0 : pos + SW'(1);
          if (pos_last) ch <= ch + CW'(1);
        end
      end
    end
  // Channel field layout: index digit, '=', D value digits MSB first, optional ','.
  always_comb begin
    ch_val = CH_W'(snap >> (int'(ch) * CH_W));
    nib    = 4'(ch_val >> (4 * (D + 1 - int'(pos))));
    body   = pos == '0 ? hex(4'(ch)) : pos == SW'(1) ? 8'h3D : pos == SW'(D + 2) ? 8'h2C : hex(nib);
    cur    = byte_cnt == '0 ? 8'h24 : byte_cnt == KW'(LEN - 2) ? 8'h0D :
             byte_cnt == KW'(LEN - 1) ? 8'h0A : body;
    bi     = 3'(bit_cnt - 4'd1);
  end
  // Outputs decode the state register directly so reset drives tx high without waiting for a clock.
  assign tx         = state != SEND ? 1'b1 : bit_cnt == 4'd0 ? 1'b0 : bit_cnt == 4'd9 ? 1'b1 : cur[bi];
  assign busy       = state == SEND || state == DONE || (state == SNAP && !suppress);
  assign frame_done = state == DONE;
endmodule

// File: tb/tb_status_frame_tx.sv
// tb_status_frame_tx: randomized self-checking bench for status_frame_tx against a byte-level frame model.
module tb_status_frame_tx;
  logic clk = 0, rst = 1;
  logic en_a = 0, force_a = 0, tx_a, busy_a, done_a;
  logic [15:0] ch_a = '0;
  logic en_b = 0, force_b = 0, tx_b, busy_b, done_b;
  logic [191:0] ch_b = '0;
  int total = 0, bad = 0;
  int lat, dlat, frame_err, cnt;
  logic [7:0] exp_q[$], got_q[$];
  logic [15:0] last_a, d;
  always #5 clk = ~clk;
  status_frame_tx #(.NUM_CH(2), .CH_W(8), .BAUD_DIV(4), .PERIOD(1000), .CHANGE_ONLY(1)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .force_send(force_a), .ch_data(ch_a),
    .tx(tx_a), .busy(busy_a), .frame_done(done_a));
  status_frame_tx #(.NUM_CH(16), .CH_W(12), .BAUD_DIV(2), .PERIOD(100000), .CHANGE_ONLY(0)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .force_send(force_b), .ch_data(ch_b),
    .tx(tx_b), .busy(busy_b), .frame_done(done_b));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] hexc(input int v);
    return v < 10 ? 8'(48 + v) : 8'(55 + v);
  endfunction
  task automatic build(input logic [1023:0] dat, input int nch, input int cw);
    logic [1023:0] t;
    exp_q = {};
    exp_q.push_back(8'h24);
    for (int i = 0; i < nch; i++) begin
      exp_q.push_back(hexc(i));
      exp_q.push_back(8'h3D);
      for (int g = cw / 4 - 1; g >= 0; g--) begin
        t = dat >> (i * cw + 4 * g);
        exp_q.push_back(hexc(int'(t[3:0])));
      end
      if (i < nch - 1) exp_q.push_back(8'h2C);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask
  function automatic logic txs(input int sel);
    return sel != 0 ? tx_b : tx_a;
  endfunction
  function automatic logic dones(input int sel);
    return sel != 0 ? done_b : done_a;
  endfunction
  task automatic get_frame(input int sel, input int n, input int bd, input int bound);
    logic [7:0] b;
    int bt, p, ferr;
    got_q = {};
    lat = -1;
    dlat = -1;
    ferr = 0;
    b = '0;
    for (int c = 1; c <= bound; c++) begin
      @(posedge clk); #1;
      if (txs(sel) == 1'b0) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) return;
    for (int k = 1; k < n * 10 * bd; k++) begin
      @(posedge clk); #1;
      if (k % bd == bd / 2) begin
        bt = k / bd;
        p = bt % 10;
        if (p == 0) begin
          if (txs(sel) !== 1'b0) ferr++;
        end else if (p == 9) begin
          if (txs(sel) !== 1'b1) ferr++;
          got_q.push_back(b);
        end else b[p-1] = txs(sel);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (dones(sel)) begin
        dlat = n * 10 * bd - 1 + c;
        break;
      end
    end
    frame_err = ferr;
  endtask
  task automatic cmp_frame(input string tag, input int nch, input int cw);
    chk({tag, "_found"}, 32'(lat > 0), 1);
    chk({tag, "_len"}, got_q.size(), 3 + nch * (cw / 4 + 3) - 1);
    chk({tag, "_ferr"}, frame_err, 0);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), i < got_q.size() ? 32'(got_q[i]) : 32'hDEAD, exp_q[i]);
  endtask
  task automatic forced_frame(input string tag, input logic [15:0] dat);
    ch_a = dat;
    build(1024'(dat), 2, 8);
    en_a = 1;
    force_a = 1;
    @(posedge clk); #1;
    force_a = 0;
    fork
      get_frame(0, exp_q.size(), 4, 50);
      begin
        repeat (6) @(posedge clk);
        #2 en_a = 0;
      end
    join
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_dlat"}, dlat, 480);
    cmp_frame(tag, 2, 8);
    @(posedge clk); #1;
    chk({tag, "_done_one"}, done_a, 0);
    chk({tag, "_idle_busy"}, busy_a, 0);
    last_a = dat;
  endtask
  initial begin
    #1;
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tx_b", tx_b, 1);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk); #1;
    forced_frame("fixed", 16'hA53C);
    forced_frame("nochange", 16'hA53C);
    for (int r = 0; r < 3; r++) forced_frame($sformatf("rnd%0d", r), 16'($urandom));
    repeat (5) @(posedge clk); #1;
    d = 16'($urandom);
    while (d == last_a) d = 16'($urandom);
    ch_a = d;
    build(1024'(d), 2, 8);
    en_a = 1;
    get_frame(0, exp_q.size(), 4, 1100);
    cmp_frame("per1", 2, 8);
    last_a = d;
    cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      @(posedge clk); #1;
      if (busy_a) cnt++;
    end
    chk("per_suppressed", cnt, 0);
    d = 16'($urandom);
    while (d == last_a) d = 16'($urandom);
    ch_a = d;
    build(1024'(d), 2, 8);
    get_frame(0, exp_q.size(), 4, 1100);
    cmp_frame("per2", 2, 8);
    last_a = d;
    en_a = 0;
    repeat (5) @(posedge clk); #1;
    d = 16'($urandom);
    ch_a = d;
    build(1024'(d), 2, 8);
    en_a = 1;
    force_a = 1;
    @(posedge clk); #1;
    force_a = 0;
    fork
      begin
        get_frame(0, exp_q.size(), 4, 50);
        chk("multi1_lat", lat, 2);
        cmp_frame("multi1", 2, 8);
        get_frame(0, exp_q.size(), 4, 50);
        chk("multi2_lat", lat, 3);
        cmp_frame("multi2", 2, 8);
      end
      begin
        repeat (60) @(posedge clk);
        repeat (3) begin
          #1 force_a = 1;
          @(posedge clk);
          #1 force_a = 0;
          repeat (40) @(posedge clk);
        end
      end
    join
    last_a = d;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (busy_a) cnt++;
    end
    chk("multi_no_third", cnt, 0);
    en_a = 0;
    repeat (3) @(posedge clk); #1;
    d = 16'($urandom);
    ch_a = d;
    en_a = 1;
    force_a = 1;
    @(posedge clk); #1;
    force_a = 0;
    lat = -1;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk); #1;
      if (tx_a == 1'b0) begin
        lat = c;
        break;
      end
    end
    chk("rstmid_start", 32'(lat > 0), 1);
    en_a = 0;
    repeat (165) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("rstmid_tx", tx_a, 1);
    chk("rstmid_busy", busy_a, 0);
    @(posedge clk); #1 rst = 0;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (busy_a || !tx_a) cnt++;
    end
    chk("rstmid_no_resume", cnt, 0);
    forced_frame("after_rst", 16'($urandom));
    d = 16'($urandom_range(0, 4095));
    for (int i = 0; i < 16; i++) ch_b[i*12 +: 12] = 12'(int'(d) + i * 12'h111);
    build(1024'(ch_b), 16, 12);
    en_b = 1;
    force_b = 1;
    @(posedge clk); #1;
    force_b = 0;
    get_frame(1, exp_q.size(), 2, 50);
    chk("big_lat", lat, 2);
    chk("big_dlat", dlat, 98 * 10 * 2);
    cmp_frame("big", 16, 12);
    en_b = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
